// File: rtl/mux_16to1_scan_ctrl.sv
// Scan sequencer for a 16:1 mux tree. It steps the select lines through all 16 channels,
// samples the mux output after a settle delay, and offers the finished 16-bit frame on valid/ready.
module mux_16to1_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        mux_out,
  output logic        sel3,
  output logic        sel2,
  output logic        sel1,
  output logic        sel0,
  output logic [15:0] frame,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // With no settle time, each select change is sampled on the very next edge.
  localparam state_t      ST_AFTER_SEL = (SETTLE_CYCLES == 32'd0) ? ST_SAMPLE : ST_SETTLE;
  localparam int unsigned CNT_LAST_I   = (SETTLE_CYCLES == 32'd0) ? 32'd0 : SETTLE_CYCLES - 32'd1;
  localparam logic [3:0]  CNT_LAST     = CNT_LAST_I[3:0];

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] frame_q, frame_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  // Next-state and datapath update for the scan sequencer.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    valid_d  = valid_q;

    case (state_q)
      ST_IDLE: begin
        sel_d = 4'd0;
        if (start) begin
          state_d  = ST_AFTER_SEL;
          cnt_d    = 4'd0;
          shadow_d = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          sel_d    = 4'd0;
          shadow_d = 16'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          sel_d    = 4'd0;
          shadow_d = 16'd0;
        end else begin
          shadow_d[sel_q] = mux_out;
          if (sel_q == 4'd15) begin
            state_d = ST_DONE;
            frame_d = shadow_d;
            valid_d = 1'b1;
          end else begin
            state_d = ST_AFTER_SEL;
            sel_d   = sel_q + 4'd1;
            cnt_d   = 4'd0;
          end
        end
      end

      ST_DONE: begin
        if (frame_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          sel_d   = 4'd0;
        end else begin
          sel_d = 4'd15;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 4'd0;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  end

  // State and output registers; reset clears any partial scan immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 4'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 16'd0;
      frame_q  <= 16'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign {sel3, sel2, sel1, sel0} = sel_q;
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;

endmodule
